// File: rtl/galaxian_input_pkg.sv
// Shared definitions for the Galaxian input front end: PS/2 scan codes,
// sequencer state type, CSJUDLR bit positions and the orientation remap.
package galaxian_input_pkg;

    // Extended (E0-prefixed) direction keys; bit 8 is ignored for these.
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    // Non-extended keys (bit 8 must be 0).
    localparam logic [7:0] SC_FIRE_A = 8'h29;
    localparam logic [7:0] SC_FIRE_B = 8'h14;
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_F2     = 8'h06;
    localparam logic [7:0] SC_KEY1   = 8'h16;
    localparam logic [7:0] SC_KEY2   = 8'h1E;
    localparam logic [7:0] SC_COIN1  = 8'h2E;
    localparam logic [7:0] SC_COIN2  = 8'h36;
    localparam logic [7:0] SC_P2_UP  = 8'h2D;
    localparam logic [7:0] SC_P2_DN  = 8'h2B;
    localparam logic [7:0] SC_P2_LT  = 8'h23;
    localparam logic [7:0] SC_P2_RT  = 8'h34;
    localparam logic [7:0] SC_FIRE2  = 8'h1C;
    localparam logic [7:0] SC_TEST   = 8'h2C;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COIN  = 2'd1,
        GAP   = 2'd2,
        START = 2'd3
    } seq_state_t;

    // CSJUDLR bit positions: {coin, start, fire, up, down, left, right}
    localparam int B_RIGHT = 0;
    localparam int B_LEFT  = 1;
    localparam int B_DOWN  = 2;
    localparam int B_UP    = 3;
    localparam int B_FIRE  = 4;
    localparam int B_START = 5;
    localparam int B_COIN  = 6;

    // udlr = {up, down, left, right}. Horizontal cabinet rotates the stick:
    // up <- left, down <- right, left <- down, right <- up.
    function automatic logic [3:0] remap_dirs(input logic horz, input logic [3:0] udlr);
        if (horz)
            return {udlr[1], udlr[0], udlr[2], udlr[3]};
        else
            return udlr;
    endfunction

endpackage

// File: rtl/galaxian_input_ctrl_if.sv
// Input/output bundle of the Galaxian input front end.
//   master : drives ps2_key, joysticks, horz; observes player vectors
//   slave  : the controller itself
interface galaxian_input_ctrl_if;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        horz;
    logic [6:0]  P1_CSJUDLR;
    logic [6:0]  P2_CSJUDLR;
    logic        service;
    logic        seq_busy;

    modport master (
        output ps2_key, joystick_0, joystick_1, horz,
        input  P1_CSJUDLR, P2_CSJUDLR, service, seq_busy
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1, horz,
        output P1_CSJUDLR, P2_CSJUDLR, service, seq_busy
    );
endinterface

// File: rtl/galaxian_coin_seq.sv
// Auto-coin sequencer: a rising request produces a coin pulse, a gap,
// then a start pulse for the requesting player.
//   clk_sys, reset_n : clock, synchronous active-low reset
//   req1, req2       : start request levels (P1 / P2)
//   coin             : P1 coin during COIN
//   start1, start2   : start pulse during START for the latched player
//   busy             : not in IDLE
//
// state | meaning
// IDLE  | waiting for a request rising edge
// COIN  | coin held for COIN_LEN cycles
// GAP   | all low for GAP_LEN cycles
// START | start held for START_LEN cycles on the selected player
module galaxian_coin_seq
    import galaxian_input_pkg::*;
#(
    parameter int COIN_LEN  = 1_200_000,
    parameter int GAP_LEN   = 1_200_000,
    parameter int START_LEN = 1_200_000,
    parameter int CNT_W     = 24
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic req1,
    input  logic req2,
    output logic coin,
    output logic start1,
    output logic start2,
    output logic busy
);

    localparam logic [CNT_W-1:0] COIN_LD  = CNT_W'(COIN_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] START_LD = CNT_W'(START_LEN - 1);

    seq_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             sel, sel_n;
    logic             req1_d, req2_d;
    logic             rise1, rise2;

    assign rise1 = req1 & ~req1_d;
    assign rise2 = req2 & ~req2_d;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sel    <= 1'b0;
            // Capture current levels so a start held through reset is not an edge.
            req1_d <= req1;
            req2_d <= req2;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sel    <= sel_n;
            req1_d <= req1;
            req2_d <= req2;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        case (state)
            IDLE: begin
                if (rise1 || rise2) begin
                    sel_n   = rise1;
                    cnt_n   = COIN_LD;
                    state_n = COIN;
                end
            end
            COIN: begin
                if (cnt == '0) begin
                    cnt_n   = GAP_LD;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    cnt_n   = START_LD;
                    state_n = START;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            START: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign coin   = (state == COIN);
    assign start1 = (state == START) &&  sel;
    assign start2 = (state == START) && !sel;
    assign busy   = (state != IDLE);

endmodule

// File: rtl/galaxian_input_ctrl.sv
// Galaxian input front end: PS/2 key decode, joystick merge, orientation
// remap and auto-coin sequencing into the two CSJUDLR player vectors.
//   clk_sys, reset_n : clock, synchronous active-low reset
//   bus (slave)      : ps2_key, joystick_0/1, horz in;
//                      P1_CSJUDLR, P2_CSJUDLR, service, seq_busy out (registered)
module galaxian_input_ctrl
    import galaxian_input_pkg::*;
#(
    parameter int COIN_LEN  = 1_200_000,
    parameter int GAP_LEN   = 1_200_000,
    parameter int START_LEN = 1_200_000,
    parameter int CNT_W     = 24
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    galaxian_input_ctrl_if.slave bus
);

    logic       old_toggle;
    logic       k_up, k_down, k_left, k_right, k_fire;
    logic       k_start1, k_start2, k_coin1, k_coin2;
    logic       k2_up, k2_down, k2_left, k2_right, k_fire2, k_test;
    logic       pressed, ext;
    logic [7:0] code;

    assign pressed = bus.ps2_key[9];
    assign ext     = bus.ps2_key[8];
    assign code    = bus.ps2_key[7:0];

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            old_toggle <= bus.ps2_key[10];
            k_up     <= 1'b0; k_down   <= 1'b0; k_left   <= 1'b0; k_right  <= 1'b0;
            k_fire   <= 1'b0; k_start1 <= 1'b0; k_start2 <= 1'b0;
            k_coin1  <= 1'b0; k_coin2  <= 1'b0;
            k2_up    <= 1'b0; k2_down  <= 1'b0; k2_left  <= 1'b0; k2_right <= 1'b0;
            k_fire2  <= 1'b0; k_test   <= 1'b0;
        end else begin
            old_toggle <= bus.ps2_key[10];
            if (bus.ps2_key[10] != old_toggle) begin
                case (code)
                    SC_UP:               k_up     <= pressed;
                    SC_DOWN:             k_down   <= pressed;
                    SC_LEFT:             k_left   <= pressed;
                    SC_RIGHT:            k_right  <= pressed;
                    SC_FIRE_A, SC_FIRE_B: if (!ext) k_fire   <= pressed;
                    SC_F1, SC_KEY1:      if (!ext) k_start1 <= pressed;
                    SC_F2, SC_KEY2:      if (!ext) k_start2 <= pressed;
                    SC_COIN1:            if (!ext) k_coin1  <= pressed;
                    SC_COIN2:            if (!ext) k_coin2  <= pressed;
                    SC_P2_UP:            if (!ext) k2_up    <= pressed;
                    SC_P2_DN:            if (!ext) k2_down  <= pressed;
                    SC_P2_LT:            if (!ext) k2_left  <= pressed;
                    SC_P2_RT:            if (!ext) k2_right <= pressed;
                    SC_FIRE2:            if (!ext) k_fire2  <= pressed;
                    SC_TEST:             if (!ext) k_test   <= pressed;
                    default: ;
                endcase
            end
        end
    end

    logic [6:0] joy;
    logic       unused_joy;
    assign joy        = bus.joystick_0[6:0] | bus.joystick_1[6:0];
    assign unused_joy = ^{bus.joystick_0[15:7], bus.joystick_1[15:7]};

    logic [3:0] p1_dirs, p2_dirs;
    assign p1_dirs = remap_dirs(bus.horz, {k_up  | joy[3], k_down  | joy[2],
                                           k_left | joy[1], k_right | joy[0]});
    assign p2_dirs = remap_dirs(bus.horz, {k2_up  | joy[3], k2_down  | joy[2],
                                           k2_left | joy[1], k2_right | joy[0]});

    logic seq_coin, seq_start1, seq_start2, busy;

    galaxian_coin_seq #(
        .COIN_LEN  (COIN_LEN),
        .GAP_LEN   (GAP_LEN),
        .START_LEN (START_LEN),
        .CNT_W     (CNT_W)
    ) u_seq (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .req1    (k_start1 | joy[5]),
        .req2    (k_start2 | joy[6]),
        .coin    (seq_coin),
        .start1  (seq_start1),
        .start2  (seq_start2),
        .busy    (busy)
    );

    logic [6:0] p1_q, p2_q;
    logic       service_q, busy_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            p1_q      <= '0;
            p2_q      <= '0;
            service_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            p1_q      <= {seq_coin | k_coin1, seq_start1, k_fire | joy[4], p1_dirs};
            p2_q      <= {k_coin2, seq_start2, k_fire2, p2_dirs};
            service_q <= k_test;
            busy_q    <= busy;
        end
    end

    assign bus.P1_CSJUDLR = p1_q;
    assign bus.P2_CSJUDLR = p2_q;
    assign bus.service    = service_q;
    assign bus.seq_busy   = busy_q;

endmodule
